// File: rtl/useq_pkg.sv
// Shared opcode, sub-opcode and state definitions for the microcode sequencer.
package useq_pkg;

    localparam logic [1:0] OP_OUT   = 2'b00;
    localparam logic [1:0] OP_JMP   = 2'b01;
    localparam logic [1:0] OP_WAIT  = 2'b10;
    localparam logic [1:0] OP_EXT   = 2'b11;

    localparam logic [1:0] EXT_MARK = 2'b00;
    localparam logic [1:0] EXT_HALT = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRIME = 3'd1,
        ST_RUN   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

endpackage

// File: rtl/useq_ctrl.sv
// Microcode sequencer driving a negedge-registered ROM: one 5-bit microword per clock,
// with output patterns, jumps, condition waits and counted loops.
module useq_ctrl
    import useq_pkg::*;
#(
    parameter int ADDR_W              = 5,
    parameter int DATA_W              = 5,
    parameter int CNT_W               = 8,
    parameter int unsigned START_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [3:0]        cond,
    input  logic [CNT_W-1:0]  loop_count,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [2:0]        out_data,
    output logic              out_strobe,
    output logic              busy,
    output logic              halted
);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_loopPc;
    logic [2:0]          r_outData;
    logic                r_outStrobe;

    state_t              w_stateNext;
    logic [ADDR_W-1:0]   w_pcNext;
    logic [CNT_W-1:0]    w_cntNext;
    logic [ADDR_W-1:0]   w_loopPcNext;
    logic [2:0]          w_outDataNext;
    logic                w_strobeNext;

    logic [1:0]          w_opClass;
    logic [2:0]          w_opArg;
    logic                w_condMet;
    logic [ADDR_W-1:0]   w_pcInc;
    logic [ADDR_W-1:0]   w_jmpTarget;

    // Instruction decode; op[2] selects the wanted polarity, so a WAIT completes on cond == ~op[2].
    always_comb begin
        w_opClass   = rom_data[4:3];
        w_opArg     = rom_data[2:0];
        w_condMet   = (cond[rom_data[1:0]] == ~rom_data[2]);
        w_pcInc     = r_pc + ADDR_W'(1);
        w_jmpTarget = ADDR_W'({rom_data[2:0], 2'b00});
    end

    always_comb begin
        w_stateNext   = r_state;
        w_pcNext      = r_pc;
        w_cntNext     = r_cnt;
        w_loopPcNext  = r_loopPc;
        w_outDataNext = r_outData;
        w_strobeNext  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_pcNext    = ADDR_W'(START_ADDR);
                    w_stateNext = ST_PRIME;
                end
            end
            ST_PRIME: begin
                w_stateNext = ST_RUN;
            end
            ST_RUN: begin
                unique case (w_opClass)
                    OP_OUT: begin
                        w_outDataNext = w_opArg;
                        w_strobeNext  = 1'b1;
                        w_pcNext      = w_pcInc;
                    end
                    OP_JMP: begin
                        w_pcNext = w_jmpTarget;
                    end
                    OP_WAIT: begin
                        if (w_condMet) begin
                            w_pcNext = w_pcInc;
                        end else begin
                            w_stateNext = ST_WAIT;
                        end
                    end
                    OP_EXT: begin
                        if (w_opArg[2]) begin
                            if (r_cnt != '0) begin
                                w_cntNext = r_cnt - CNT_W'(1);
                                w_pcNext  = r_loopPc;
                            end else begin
                                w_pcNext = w_pcInc;
                            end
                        end else if (w_opArg[1:0] == EXT_MARK) begin
                            w_loopPcNext = w_pcInc;
                            w_cntNext    = loop_count;
                            w_pcNext     = w_pcInc;
                        end else if (w_opArg[1:0] == EXT_HALT) begin
                            w_stateNext = ST_HALT;
                        end else begin
                            w_pcNext = w_pcInc;
                        end
                    end
                endcase
            end
            ST_WAIT: begin
                // The pc is held, so the ROM keeps presenting the same WAIT microword.
                if (w_condMet) begin
                    w_pcNext    = w_pcInc;
                    w_stateNext = ST_RUN;
                end
            end
            ST_HALT: begin
                if (!start) begin
                    w_stateNext = ST_IDLE;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_pc        <= '0;
            r_cnt       <= '0;
            r_loopPc    <= '0;
            r_outData   <= '0;
            r_outStrobe <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_pc        <= w_pcNext;
            r_cnt       <= w_cntNext;
            r_loopPc    <= w_loopPcNext;
            r_outData   <= w_outDataNext;
            r_outStrobe <= w_strobeNext;
        end
    end

    // rom_addr follows pc without a register so the negedge ROM read sees the new address in time.
    assign rom_addr   = r_pc;
    assign out_data   = r_outData;
    assign out_strobe = r_outStrobe;
    assign busy       = (r_state == ST_PRIME) || (r_state == ST_RUN) || (r_state == ST_WAIT);
    assign halted     = (r_state == ST_HALT);

endmodule

// File: tb/tb_useq_ctrl.sv
// Self-checking bench for useq_ctrl: directed scenarios plus random programs,
// compared cycle by cycle against an instruction-level interpreter of the microcode.
module tb_useq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] cond;
    logic [7:0] loopCount;
    logic [4:0] romAddr;
    logic [4:0] romData;
    logic [2:0] outData;
    logic       outStrobe;
    logic       busy;
    logic       halted;

    logic [4:0] rom [32];

    int errors = 0;
    int checks = 0;

    // Interpreter state: mode 0 idle, 1 priming, 2 executing, 3 halted.
    int mMode, mPc, mCnt, mLpc, mOut, mStb;
    int cycleNo = 0;
    int strobeSix;

    localparam logic [4:0] I_NOP  = 5'b11010;
    localparam logic [4:0] I_HALT = 5'b11001;
    localparam logic [4:0] I_MARK = 5'b11000;
    localparam logic [4:0] I_DJNZ = 5'b11100;

    useq_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cond       (cond),
        .loop_count (loopCount),
        .rom_addr   (romAddr),
        .rom_data   (romData),
        .out_data   (outData),
        .out_strobe (outStrobe),
        .busy       (busy),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) romData <= rom[romAddr];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mMode = 0; mPc = 0; mCnt = 0; mLpc = 0; mOut = 0; mStb = 0;
    endtask

    task automatic modelStep(input logic s, input logic [3:0] c);
        logic [4:0] w;
        mStb = 0;
        case (mMode)
            0: if (s) begin mPc = 0; mMode = 1; end
            1: mMode = 2;
            2: begin
                w = rom[mPc];
                case (w[4:3])
                    2'd0: begin mOut = int'(w[2:0]); mStb = 1; mPc = mPc + 1; end
                    2'd1: mPc = int'(w[2:0]) * 4;
                    2'd2: if (c[w[1:0]] != w[2]) mPc = mPc + 1;
                    default: begin
                        if (w[2]) begin
                            if (mCnt != 0) begin mCnt = mCnt - 1; mPc = mLpc; end
                            else mPc = mPc + 1;
                        end else if (w[1:0] == 2'd0) begin
                            mLpc = (mPc + 1) % 32; mCnt = int'(loopCount); mPc = mPc + 1;
                        end else if (w[1:0] == 2'd1) begin
                            mMode = 3;
                        end else begin
                            mPc = mPc + 1;
                        end
                    end
                endcase
                mPc = mPc % 32;
            end
            default: if (!s) mMode = 0;
        endcase
    endtask

    // Drive one cycle of inputs, advance the interpreter, and compare after the edge.
    task automatic applyStimulus(input logic s, input logic [3:0] c);
        logic [10:0] exp;
        start = s;
        cond  = c;
        modelStep(s, c);
        @(posedge clk);
        #1;
        cycleNo++;
        exp = {5'(mPc), 3'(mOut), mStb[0], (mMode == 1 || mMode == 2), (mMode == 3)};
        checkOutput($sformatf("cyc%0d", cycleNo), 32'({romAddr, outData, outStrobe, busy, halted}), 32'(exp));
        if (outStrobe && outData == 3'd6) strobeSix++;
    endtask

    // Asserts reset mid-cycle and checks that outputs clear before any clock edge.
    task automatic doReset();
        rst_n = 1'b0;
        start = 1'b0;
        cond  = 4'h0;
        #2;
        checkOutput("reset", 32'({romAddr, outData, outStrobe, busy, halted}), 32'd0);
        modelReset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic loadNops();
        for (int i = 0; i < 32; i++) rom[i] = I_NOP;
    endtask

    initial begin
        int prevAddr;
        rst_n = 1'b0;
        start = 1'b0;
        cond = 4'h0;
        loopCount = 8'd0;
        loadNops();
        modelReset();
        @(posedge clk);
        #1;

        // Single OUT then HALT.
        loadNops();
        rom[0] = 5'b00101;
        rom[1] = I_HALT;
        doReset();
        applyStimulus(1'b1, 4'h0);
        applyStimulus(1'b1, 4'h0);
        applyStimulus(1'b1, 4'h0);
        checkOutput("t1_out", 32'({outStrobe, outData}), 32'({1'b1, 3'd5}));
        applyStimulus(1'b1, 4'h0);
        checkOutput("t1_halt", 32'({halted, romAddr}), 32'({1'b1, 5'd1}));
        applyStimulus(1'b1, 4'h0);
        checkOutput("t1_hold", 32'({halted, romAddr, outStrobe}), 32'({1'b1, 5'd1, 1'b0}));

        // Jump into the top quarter of the ROM.
        loadNops();
        rom[0]  = 5'b01111;
        rom[28] = 5'b00011;
        rom[29] = I_HALT;
        doReset();
        applyStimulus(1'b1, 4'h0);
        applyStimulus(1'b1, 4'h0);
        checkOutput("t2_a0", 32'(romAddr), 32'd0);
        applyStimulus(1'b1, 4'h0);
        checkOutput("t2_a28", 32'(romAddr), 32'd28);
        applyStimulus(1'b1, 4'h0);
        checkOutput("t2_a29", 32'({romAddr, outData}), 32'({5'd29, 3'd3}));
        applyStimulus(1'b1, 4'h0);

        // Wait on cond[2] high.
        loadNops();
        rom[0] = 5'b10010;
        rom[1] = 5'b00001;
        rom[2] = I_HALT;
        doReset();
        applyStimulus(1'b1, 4'h0);
        applyStimulus(1'b1, 4'h0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 4'h0);
            checkOutput("t3_wait", 32'({busy, romAddr, outStrobe}), 32'({1'b1, 5'd0, 1'b0}));
        end
        applyStimulus(1'b1, 4'h4);
        checkOutput("t3_rise", 32'({romAddr, outStrobe}), 32'({5'd1, 1'b0}));
        applyStimulus(1'b1, 4'h4);
        checkOutput("t3_out", 32'({outStrobe, outData}), 32'({1'b1, 3'd1}));
        applyStimulus(1'b1, 4'h4);

        // Counted loop, then restart from HALT.
        loadNops();
        rom[0] = I_MARK;
        rom[1] = 5'b00110;
        rom[2] = I_DJNZ;
        rom[3] = I_HALT;
        loopCount = 8'd3;
        doReset();
        strobeSix = 0;
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 4'h0);
        checkOutput("t4_count", 32'(strobeSix), 32'd4);
        checkOutput("t4_halt", 32'(halted), 32'd1);
        applyStimulus(1'b0, 4'h0);
        checkOutput("t6_idle", 32'({busy, halted}), 32'd0);
        strobeSix = 0;
        applyStimulus(1'b1, 4'h0);
        checkOutput("t6_prime", 32'({busy, romAddr}), 32'({1'b1, 5'd0}));
        for (int i = 0; i < 15; i++) applyStimulus(1'b1, 4'h0);
        checkOutput("t6_count", 32'(strobeSix), 32'd4);
        checkOutput("t6_halt", 32'(halted), 32'd1);

        // All NOPs: pc wraps 31 -> 0, then reset lands mid-program.
        loadNops();
        doReset();
        prevAddr = 0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, 4'h0);
            if (prevAddr == 31) checkOutput("t5_wrap", 32'(romAddr), 32'd0);
            prevAddr = int'(romAddr);
        end
        checkOutput("t5_busy", 32'(busy), 32'd1);
        doReset();

        // Random programs, conditions and start levels.
        for (int run = 0; run < 6; run++) begin
            for (int i = 0; i < 32; i++) rom[i] = 5'($urandom);
            loopCount = 8'($urandom_range(0, 4));
            doReset();
            for (int i = 0; i < 50; i++) begin
                applyStimulus(($urandom_range(0, 7) != 0), 4'($urandom));
            end
        end
        doReset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
